param_data_memory: RTL and testbench
====================================

# param_data_memory

Parametrised, multi-cycle data memory for the RV32IM pipeline's MEM stage. It replaces the fixed 1024-word zero-latency memory with a configurable depth and access latency and a byte-enable store path. It adds a post-reset clear sweep and a fault flag for misaligned, out-of-range and undefined accesses. It stalls the pipeline through the existing `busywait` handshake.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, ≥ 4.
- `LATENCY`, 2: cycles spent in ACCESS per request; ≥ 1.
- `IDX_W`, $clog2(DEPTH_WORDS): word index width (derived).

Ports:
- `Clock`  in  1  clock; all state updates on posedge.
- `Reset`  in  1  reset; asynchronous, active-high.
- `Read`  in  1  load request; held by requester until `busywait` falls.
- `Write`  in  1  store request; same hold rule.
- `Address`  in  32  byte address.
- `Write_data`  in  32  store data; lanes taken from low bits.
- `Func3`  in  3  RV32 width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `Read_data`  out  32  registered load result.
- `busywait`  out  1  stall request to pipeline.
- `fault`  out  1  one-cycle pulse in DONE for a rejected access.

## Operation
- **FSM states:** CLEAR, IDLE, ACCESS, DONE.
- **CLEAR**
  - Entered on reset.
  - Writes zero to word `clr_idx` each cycle; `clr_idx` runs 0 → DEPTH_WORDS−1.
  - After the last word, goes to IDLE.
- **IDLE**
  - `Read` XOR `Write` high latches a request: type, Address, Write_data and Func3 are captured.
  - Goes to ACCESS with `cnt = LATENCY−1`.
  - Read and Write both high is an illegal request: latched as a fault-only request (no memory effect).
- **ACCESS**
  - `cnt` decrements each cycle.
  - At `cnt == 0`, the access executes on that posedge and the FSM goes to DONE.
- **DONE**
  - `busywait` = 0, so the pipeline advances on this edge.
  - Always returns to IDLE; there is no back-to-back acceptance from DONE.
- **Fault conditions**, checked on the latched request. A fault means no memory change and `Read_data` = 0 for loads.
  - Word index `Address[31:2] ≥ DEPTH_WORDS`.
  - Func3 011/110/111, or stores with Func3 100/101.
  - LH/LHU/SH with `Address[0]` = 1.
  - LW/SW with `Address[1:0] ≠ 0`.
  - Read and Write both high.
- **Loads**
  - Byte lane is `Address[1:0]`; half lane is `Address[1]`.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- **Stores** use 4-bit byte enables:
  - SB: `1 << Address[1:0]`.
  - SH: `0011` or `1100`.
  - SW: `1111`.
  - Unselected bytes keep their value.

## Timing
- **Reset values:** `Read_data` = 0, `fault` = 0, `busywait` = 1, state = CLEAR, `clr_idx` = 0.
- **`busywait`** = (state == CLEAR) | (state == ACCESS) | (state == IDLE & (Read | Write)). The IDLE term is combinational, so the stall is visible in the request's first cycle.
- **Clear time:** DEPTH_WORDS cycles after `Reset` deasserts.
- **Latency:** a request is stalled for exactly 1+LATENCY cycles, and its result is available in the DONE cycle.
- **`Read_data`** is updated only on a load completion (fault → 0) and holds otherwise.
- **Store effect** is visible to a load issued after DONE.
- **`fault`** is high only in DONE.
- **Reset mid-access:** the latched request is discarded, no partial store occurs, and the sweep restarts.
- **Requests during CLEAR** are not latched. `busywait` stays high; the request is accepted in the first IDLE cycle.
- **Request dropped before DONE:** the request still completes, because it was latched at acceptance.

## Structure
- **Shared package `mem_pkg`:**
  - Func3 width constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - `mem_state_t` enum.
  - `func3_to_be` function.
  - `load_extract` function (lane select + extension).
- **Sub-module `sram_1rw_be`:**
  - DEPTH_WORDS × 32, single port, synchronous write with 4-bit byte enable, asynchronous read.
  - Used by the FSM for both clear and access.
- The top level holds the FSM, counter, request latch and fault decode.

## Test plan
- **Reset, then clear:** DEPTH_WORDS=16, LATENCY=2. Pulse Reset → `busywait` high for 16 cycles; LW 0x0 then LW 0x3C return 0; `fault` = 0.
- **Store then load:** SW 0x8 ← 0xDEADBEEF, then LW 0x8 → 0xDEADBEEF. `busywait` high for 3 cycles per request.
- **Byte and half lanes:** SB 0x9 ← 0x80, LB 0x9 → 0xFFFFFF80, LBU 0x9 → 0x00000080. SH 0xA ← 0x1234, LW 0x8 → 0x12348000.
- **Faults:** each of the following → `fault` pulse and memory unchanged (confirmed by LW):
  - LW 0x2 → `Read_data` 0.
  - SH 0x5.
  - LW 0x40 (out of range).
  - Func3 = 011.
  - Read & Write both high.
- **Reset mid-access:** SW 0x4 ← 0xFFFFFFFF with Reset asserted in ACCESS → after the sweep, LW 0x4 returns 0.
- **LATENCY sweep:** LATENCY = 1 and 5. For each, `busywait` high for exactly 2 and 6 cycles per request, and data is correct.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the parametrised data memory.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_ACCESS,
    S_DONE
  } mem_state_t;

  function automatic logic [3:0] func3_to_be(input logic [2:0] f3, input logic [1:0] lane);
    logic [3:0] be;
    case (f3)
      F3_B:    be = 4'b0001 << lane;
      F3_H:    be = lane[1] ? 4'b1100 : 4'b0011;
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the low lane so any enabled byte position sees the right data.
  function automatic logic [31:0] store_align(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (f3)
      F3_B:    d = {4{wd[7:0]}};
      F3_H:    d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'b0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'b0, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sram_1rw_be.sv
// Single-port word SRAM: synchronous byte-enabled write, asynchronous read.
module sram_1rw_be #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/param_data_memory.sv
// Multi-cycle MEM-stage data memory: clear sweep, latched request, fault decode.
module param_data_memory
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Read,
  input  logic        Write,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic [2:0]  Func3,
  output logic [31:0] Read_data,
  output logic        busywait,
  output logic        fault
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  mem_state_t       state_q;
  logic [IDX_W-1:0] clr_idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             req_rd_q, req_wr_q;
  logic [31:0]      req_addr_q, req_wdata_q;
  logic [2:0]       req_f3_q;
  logic [31:0]      rdata_q;
  logic             fault_q;

  logic             req_fault, exec;
  logic             sram_we;
  logic [3:0]       sram_be;
  logic [IDX_W-1:0] sram_addr;
  logic [31:0]      sram_wdata, sram_rdata;

  assign exec = (state_q == S_ACCESS) && (cnt_q == '0);

  always_comb begin
    req_fault = 1'b0;
    if (req_rd_q && req_wr_q) req_fault = 1'b1;
    if ({2'b00, req_addr_q[31:2]} >= 32'(DEPTH_WORDS)) req_fault = 1'b1;
    case (req_f3_q)
      F3_B:    ;
      F3_H:    if (req_addr_q[0]) req_fault = 1'b1;
      F3_W:    if (req_addr_q[1:0] != 2'b00) req_fault = 1'b1;
      F3_BU:   if (req_wr_q) req_fault = 1'b1;
      F3_HU:   if (req_wr_q || req_addr_q[0]) req_fault = 1'b1;
      default: req_fault = 1'b1;
    endcase
  end

  // The sweep and the access share the single SRAM port.
  always_comb begin
    sram_we    = 1'b0;
    sram_be    = '0;
    sram_addr  = req_addr_q[IDX_W+1:2];
    sram_wdata = store_align(req_f3_q, req_wdata_q);
    if (state_q == S_CLEAR) begin
      sram_we    = 1'b1;
      sram_be    = '1;
      sram_addr  = clr_idx_q;
      sram_wdata = '0;
    end else if (exec && req_wr_q && !req_fault) begin
      sram_we = 1'b1;
      sram_be = func3_to_be(req_f3_q, req_addr_q[1:0]);
    end
  end

  sram_1rw_be #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_sram (
    .clk_i  (Clock),
    .we_i   (sram_we),
    .be_i   (sram_be),
    .addr_i (sram_addr),
    .wdata_i(sram_wdata),
    .rdata_o(sram_rdata)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_CLEAR;
      clr_idx_q   <= '0;
      cnt_q       <= '0;
      req_rd_q    <= 1'b0;
      req_wr_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_f3_q    <= '0;
      rdata_q     <= '0;
      fault_q     <= 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          clr_idx_q <= clr_idx_q + 1'b1;
          if (clr_idx_q == IDX_W'(DEPTH_WORDS - 1)) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (Read || Write) begin
            req_rd_q    <= Read;
            req_wr_q    <= Write;
            req_addr_q  <= Address;
            req_wdata_q <= Write_data;
            req_f3_q    <= Func3;
            cnt_q       <= CNT_W'(LATENCY - 1);
            state_q     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt_q == '0) begin
            fault_q <= req_fault;
            if (req_rd_q && !req_wr_q)
              rdata_q <= req_fault ? '0 : load_extract(sram_rdata, req_f3_q, req_addr_q[1:0]);
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          fault_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  assign busywait  = (state_q == S_CLEAR) || (state_q == S_ACCESS) ||
                     ((state_q == S_IDLE) && (Read || Write));
  assign Read_data = rdata_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_param_data_memory.sv
// Directed bench: three instances (LATENCY 2, 1, 5) sharing clock, reset and address/data.
module tb_param_data_memory;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Read = 1'b0, Write = 1'b0;
  logic [31:0] Address = '0, Write_data = '0;
  logic [2:0]  Func3 = '0;
  int          sel = 0;

  logic        rd0, wr0, rd1, wr1, rd5, wr5;
  logic [31:0] rdata0, rdata1, rdata5, rdata;
  logic        bw0, bw1, bw5, bw;
  logic        flt0, flt1, flt5, flt;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  always_comb begin
    rd0 = Read && (sel == 0);  wr0 = Write && (sel == 0);
    rd1 = Read && (sel == 1);  wr1 = Write && (sel == 1);
    rd5 = Read && (sel == 2);  wr5 = Write && (sel == 2);
    case (sel)
      1:       begin rdata = rdata1; bw = bw1; flt = flt1; end
      2:       begin rdata = rdata5; bw = bw5; flt = flt5; end
      default: begin rdata = rdata0; bw = bw0; flt = flt0; end
    endcase
  end

  param_data_memory #(.DEPTH_WORDS(16), .LATENCY(2)) u_lat2 (
    .Clock(Clock), .Reset(Reset), .Read(rd0), .Write(wr0), .Address(Address),
    .Write_data(Write_data), .Func3(Func3), .Read_data(rdata0), .busywait(bw0), .fault(flt0));
  param_data_memory #(.DEPTH_WORDS(16), .LATENCY(1)) u_lat1 (
    .Clock(Clock), .Reset(Reset), .Read(rd1), .Write(wr1), .Address(Address),
    .Write_data(Write_data), .Func3(Func3), .Read_data(rdata1), .busywait(bw1), .fault(flt1));
  param_data_memory #(.DEPTH_WORDS(16), .LATENCY(5)) u_lat5 (
    .Clock(Clock), .Reset(Reset), .Read(rd5), .Write(wr5), .Address(Address),
    .Write_data(Write_data), .Func3(Func3), .Read_data(rdata5), .busywait(bw5), .fault(flt5));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Counts the busywait-high cycles of the clear sweep after Reset drops.
  task automatic count_clear(input string tag);
    int n = 0;
    while (bw && n < 100) begin
      n++;
      @(negedge Clock);
    end
    check_eq(tag, n, 16);
  endtask

  task automatic do_req(input string tag, input int lat, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3,
                        input logic exp_fault, input logic [31:0] exp_rdata);
    int n = 0;
    @(negedge Clock);
    Read = rd; Write = wr; Address = addr; Write_data = wd; Func3 = f3;
    #1;
    while (bw && n < 50) begin
      n++;
      @(negedge Clock);
    end
    check_eq({tag, ".stall"}, n, 1 + lat);
    check_eq({tag, ".fault"}, {31'b0, flt}, {31'b0, exp_fault});
    check_eq({tag, ".rdata"}, rdata, exp_rdata);
    Read = 1'b0; Write = 1'b0;
    @(negedge Clock);
    check_eq({tag, ".fault_low"}, {31'b0, flt}, 32'h0);
  endtask

  initial begin
    sel = 0;
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    check_eq("rst.busywait", {31'b0, bw}, 32'h1);
    check_eq("rst.fault", {31'b0, flt}, 32'h0);
    check_eq("rst.rdata", rdata, 32'h0);
    Reset = 1'b0;
    #1;
    count_clear("clear.cycles");

    do_req("lw0",   2, 1, 0, 32'h0,  32'h0, 3'b010, 0, 32'h0);
    do_req("lw3c",  2, 1, 0, 32'h3C, 32'h0, 3'b010, 0, 32'h0);

    do_req("sb9",   2, 0, 1, 32'h9, 32'h80,   3'b000, 0, 32'h0);
    do_req("lb9",   2, 1, 0, 32'h9, 32'h0,    3'b000, 0, 32'hFFFFFF80);
    do_req("lbu9",  2, 1, 0, 32'h9, 32'h0,    3'b100, 0, 32'h00000080);
    do_req("sha",   2, 0, 1, 32'hA, 32'h1234, 3'b001, 0, 32'h00000080);
    do_req("lw8a",  2, 1, 0, 32'h8, 32'h0,    3'b010, 0, 32'h12348000);

    do_req("sw8",   2, 0, 1, 32'h8, 32'hDEADBEEF, 3'b010, 0, 32'h12348000);
    do_req("lw8b",  2, 1, 0, 32'h8, 32'h0,        3'b010, 0, 32'hDEADBEEF);

    do_req("f.lw2",   2, 1, 0, 32'h2,  32'h0,    3'b010, 1, 32'h0);
    do_req("f.sh5",   2, 0, 1, 32'h5,  32'hAAAA, 3'b001, 1, 32'h0);
    do_req("f.lw4",   2, 1, 0, 32'h4,  32'h0,    3'b010, 0, 32'h0);
    do_req("f.lw40",  2, 1, 0, 32'h40, 32'h0,    3'b010, 1, 32'h0);
    do_req("f.ld011", 2, 1, 0, 32'h8,  32'h0,    3'b011, 1, 32'h0);
    do_req("f.st011", 2, 0, 1, 32'h8,  32'h0,    3'b011, 1, 32'h0);
    do_req("f.both",  2, 1, 1, 32'h8,  32'h0,    3'b010, 1, 32'h0);
    do_req("f.sbu",   2, 0, 1, 32'h8,  32'h0,    3'b100, 1, 32'h0);
    do_req("f.lw8",   2, 1, 0, 32'h8,  32'h0,    3'b010, 0, 32'hDEADBEEF);

    // Reset lands while the store is still in ACCESS.
    @(negedge Clock);
    Read = 1'b0; Write = 1'b1; Address = 32'h4; Write_data = 32'hFFFFFFFF; Func3 = 3'b010;
    @(negedge Clock);
    check_eq("mid.busy", {31'b0, bw}, 32'h1);
    Reset = 1'b1; Write = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
    #1;
    count_clear("mid.clear");
    do_req("mid.lw4", 2, 1, 0, 32'h4, 32'h0, 3'b010, 0, 32'h0);
    do_req("mid.lw8", 2, 1, 0, 32'h8, 32'h0, 3'b010, 0, 32'h0);

    sel = 1;
    do_req("l1.sw",  1, 0, 1, 32'hC, 32'hCAFEF00D, 3'b010, 0, 32'h0);
    do_req("l1.lw",  1, 1, 0, 32'hC, 32'h0,        3'b010, 0, 32'hCAFEF00D);
    do_req("l1.lb",  1, 1, 0, 32'hF, 32'h0,        3'b000, 0, 32'hFFFFFFCA);

    sel = 2;
    do_req("l5.sh",  5, 0, 1, 32'h2, 32'hBEEF, 3'b001, 0, 32'h0);
    do_req("l5.lh",  5, 1, 0, 32'h2, 32'h0,    3'b001, 0, 32'hFFFFBEEF);
    do_req("l5.lhu", 5, 1, 0, 32'h2, 32'h0,    3'b101, 0, 32'h0000BEEF);
    do_req("l5.lw",  5, 1, 0, 32'h0, 32'h0,    3'b010, 0, 32'hBEEF0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
